// File: rtl/ac2_acc_bank.sv
// ac2_acc_bank
//   Write-side accumulator bank for the AC2 datapath. Adder results are
//   stored into one of four lanes. All lanes are exposed in parallel so the
//   read mux can feed them back to the adder. A sequenced drain port streams
//   lanes 0..3 out over a valid/ready handshake and then clears the bank.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   sum_in, sel_w_en     adder result and its destination lane
//   wr_valid             sum_in/sel_w_en valid this cycle
//   clear                zero all lanes and write counters (IDLE only)
//   drain_start          begin draining lanes 0..3 (IDLE only)
//   out_ready            downstream accepts dout
//   acc0..acc3           registered lane contents
//   dout, dout_idx       drained lane value and its index
//   out_valid, busy      high while draining
//   drain_done           one-cycle pulse after lane 3 is accepted
//   wr_drop              one-cycle pulse when a write is rejected
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | lanes accept writes; clear and drain_start are honoured
// DRAIN | lane[idx] presented on dout; writes are rejected with wr_drop
module ac2_acc_bank #(
  parameter  int M  = 16,
  parameter  int Pa = 8,
  localparam int W  = $clog2(M) + Pa + 1,
  localparam int CW = $clog2(M) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sum_in,
  input  logic [1:0]   sel_w_en,
  input  logic         wr_valid,
  input  logic         clear,
  input  logic         drain_start,
  input  logic         out_ready,
  output logic [W-1:0] acc0,
  output logic [W-1:0] acc1,
  output logic [W-1:0] acc2,
  output logic [W-1:0] acc3,
  output logic [W-1:0] dout,
  output logic [1:0]   dout_idx,
  output logic         out_valid,
  output logic         busy,
  output logic         drain_done,
  output logic         wr_drop
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [W-1:0]    lane_q [4];
  logic [W-1:0]    lane_d [4];
  logic [CW-1:0]   cnt_q  [4];
  logic [CW-1:0]   cnt_d  [4];
  logic            wr_drop_q, wr_drop_d;
  logic            drain_done_q, drain_done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      wr_drop_q    <= 1'b0;
      drain_done_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        lane_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wr_drop_q    <= wr_drop_d;
      drain_done_q <= drain_done_d;
      for (int i = 0; i < 4; i++) begin
        lane_q[i] <= lane_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wr_drop_d    = 1'b0;
    drain_done_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lane_d[i] = lane_q[i];
      cnt_d[i]  = cnt_q[i];
    end

    case (state_q)
      IDLE: begin
        if (clear) begin
          // clear swallows a same-cycle write and drain_start silently
          for (int i = 0; i < 4; i++) begin
            lane_d[i] = '0;
            cnt_d[i]  = '0;
          end
        end else begin
          if (wr_valid) begin
            if (cnt_q[sel_w_en] < CW'(M)) begin
              lane_d[sel_w_en] = sum_in;
              cnt_d[sel_w_en]  = cnt_q[sel_w_en] + CW'(1);
            end else begin
              wr_drop_d = 1'b1;
            end
          end
          if (drain_start) begin
            state_d = DRAIN;
            idx_d   = 2'd0;
          end
        end
      end

      DRAIN: begin
        if (wr_valid) begin
          wr_drop_d = 1'b1;
        end
        if (out_ready) begin
          if (idx_q == 2'd3) begin
            for (int i = 0; i < 4; i++) begin
              lane_d[i] = '0;
              cnt_d[i]  = '0;
            end
            state_d      = IDLE;
            idx_d        = 2'd0;
            drain_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  assign acc0       = lane_q[0];
  assign acc1       = lane_q[1];
  assign acc2       = lane_q[2];
  assign acc3       = lane_q[3];
  assign busy       = (state_q == DRAIN);
  assign out_valid  = busy;
  assign dout       = busy ? lane_q[idx_q] : '0;
  assign dout_idx   = busy ? idx_q : 2'd0;
  assign wr_drop    = wr_drop_q;
  assign drain_done = drain_done_q;

endmodule

// File: tb/tb_ac2_acc_bank.sv
module tb_ac2_acc_bank;

  localparam int M = 16;
  localparam int W = 13;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sum_in;
  logic [1:0]   sel_w_en;
  logic         wr_valid, clear, drain_start, out_ready;
  logic [W-1:0] acc0, acc1, acc2, acc3, dout;
  logic [1:0]   dout_idx;
  logic         out_valid, busy, drain_done, wr_drop;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  int lane_m [4];
  int cnt_m  [4];
  bit drn;
  int idx;
  bit drop_m, done_m;

  ac2_acc_bank #(.M(M), .Pa(8)) dut (
    .clk(clk), .rst(rst), .sum_in(sum_in), .sel_w_en(sel_w_en),
    .wr_valid(wr_valid), .clear(clear), .drain_start(drain_start),
    .out_ready(out_ready), .acc0(acc0), .acc1(acc1), .acc2(acc2),
    .acc3(acc3), .dout(dout), .dout_idx(dout_idx), .out_valid(out_valid),
    .busy(busy), .drain_done(drain_done), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic zero_bank();
    for (int i = 0; i < 4; i++) begin
      lane_m[i] = 0;
      cnt_m[i]  = 0;
    end
  endtask

  // One clock of the bank described in terms of its rules.
  task automatic model_step();
    drop_m = 0;
    done_m = 0;
    if (rst) begin
      zero_bank();
      drn = 0;
      idx = 0;
    end else if (!drn) begin
      if (clear) begin
        zero_bank();
      end else begin
        if (wr_valid) begin
          if (cnt_m[sel_w_en] < M) begin
            lane_m[sel_w_en] = int'(sum_in);
            cnt_m[sel_w_en]  = cnt_m[sel_w_en] + 1;
          end else begin
            drop_m = 1;
          end
        end
        if (drain_start) begin
          drn = 1;
          idx = 0;
        end
      end
    end else begin
      if (wr_valid) drop_m = 1;
      if (out_ready) begin
        if (idx == 3) begin
          zero_bank();
          drn    = 0;
          idx    = 0;
          done_m = 1;
        end else begin
          idx = idx + 1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("acc0", acc0, lane_m[0]);
    chk("acc1", acc1, lane_m[1]);
    chk("acc2", acc2, lane_m[2]);
    chk("acc3", acc3, lane_m[3]);
    chk("out_valid", out_valid, drn);
    chk("busy", busy, drn);
    chk("dout", dout, drn ? lane_m[idx] : 0);
    chk("dout_idx", dout_idx, drn ? idx : 0);
    chk("wr_drop", wr_drop, drop_m);
    chk("drain_done", drain_done, done_m);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    rst = 0; wr_valid = 0; clear = 0; drain_start = 0; out_ready = 0;
    sum_in = '0; sel_w_en = 2'd0;
  endtask

  task automatic wr(input int sel, input int val);
    wr_valid = 1; sel_w_en = 2'(sel); sum_in = W'(val);
    step();
    wr_valid = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    zero_bank();
    drn = 0; idx = 0; drop_m = 0; done_m = 0;

    // reset then write lanes
    step();
    step();
    chk("reset_busy", busy, 0);
    chk("reset_acc0", acc0, 0);
    rst = 0;
    wr(0, 'h10);
    chk("wr_acc0", acc0, 'h10);
    wr(2, 'h2A);
    chk("wr_acc2", acc2, 'h2A);
    chk("wr_acc1", acc1, 0);
    chk("wr_acc3", acc3, 0);
    step();
    chk("wr_nodrop", wr_drop, 0);

    // lane saturation
    for (int v = 1; v <= 17; v++) begin
      wr(1, v);
      if (v == 16) chk("sat_acc1_16", acc1, 16);
      if (v == 17) begin
        chk("sat_acc1_held", acc1, 16);
        chk("sat_drop", wr_drop, 1);
      end
    end
    step();
    chk("sat_drop_pulse", wr_drop, 0);
    clear = 1; step(); clear = 0;

    // drain with backpressure
    wr(0, 5); wr(1, 6); wr(2, 7); wr(3, 8);
    drain_start = 1; step(); drain_start = 0;
    chk("drn_first", dout, 5);
    begin
      bit rdy [6] = '{0, 1, 0, 1, 1, 1};
      int dexp [6] = '{5, 6, 6, 7, 8, 0};
      for (int k = 0; k < 6; k++) begin
        out_ready = rdy[k];
        step();
        chk("drn_seq", dout, dexp[k]);
      end
    end
    out_ready = 0;
    chk("drn_done", drain_done, 1);
    chk("drn_busy", busy, 0);
    chk("drn_acc3", acc3, 0);
    step();
    chk("drn_done_pulse", drain_done, 0);

    // clear + write
    wr(3, 'h11);
    clear = 1; wr_valid = 1; sel_w_en = 2'd3; sum_in = W'('h99);
    step();
    clear = 0; wr_valid = 0;
    chk("clr_acc3", acc3, 0);
    chk("clr_nodrop", wr_drop, 0);

    // clear + drain_start
    clear = 1; drain_start = 1; step(); clear = 0; drain_start = 0;
    chk("clr_ds_busy", busy, 0);

    // write during drain
    wr(0, 'h21); wr(1, 'h22);
    drain_start = 1; step(); drain_start = 0;
    wr(0, 'h1FF);
    chk("drn_wr_drop", wr_drop, 1);
    chk("drn_wr_acc0", acc0, 'h21);
    out_ready = 1;
    repeat (4) step();
    out_ready = 0;

    // reset mid-drain
    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
    drain_start = 1; step(); drain_start = 0;
    out_ready = 1; step(); step();
    chk("mid_idx", dout_idx, 2);
    rst = 1; out_ready = 0; step(); rst = 0;
    chk("mid_valid", out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_acc0", acc0, 0);
    chk("mid_done", drain_done, 0);

    // write coincident with drain_start
    wr_valid = 1; sel_w_en = 2'd0; sum_in = W'(3); drain_start = 1;
    step();
    wr_valid = 0; drain_start = 0;
    chk("wds_dout", dout, 3);
    chk("wds_idx", dout_idx, 0);
    out_ready = 1;
    repeat (4) step();
    out_ready = 0;

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 79) == 0);
      wr_valid    = ($urandom_range(0, 2) != 0);
      sel_w_en    = 2'($urandom_range(0, 3));
      sum_in      = W'($urandom_range(0, (1 << W) - 1));
      clear       = ($urandom_range(0, 39) == 0);
      drain_start = ($urandom_range(0, 24) == 0);
      out_ready   = ($urandom_range(0, 1) == 1);
      step();
    end
    idle_inputs();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ac2_acc_bank.md
Name: ac2_acc_bank

Overview:
- Write-side counterpart of the AC2 read mux. Receives AC2_adder results and writes each into one of four accumulator lanes selected by sel_w_en.
- Exposes all four lanes in parallel so the read mux can feed them back to the adder.
- Provides a sequenced drain port that streams lanes 0..3 out with a valid/ready handshake, then clears the bank.

Parameters:
M, 16, register dimension; also the maximum number of writes per lane between clears
Pa, 8, activation precision; lane width W = $clog2(M)+Pa+1

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
sum_in  in  W  result from AC2_adder
sel_w_en  in  2  destination lane for sum_in
wr_valid  in  1  sum_in/sel_w_en valid this cycle
clear  in  1  zero all lanes and counters
drain_start  in  1  begin draining lanes 0..3
out_ready  in  1  downstream accepts dout
acc0, acc1, acc2, acc3  out  W each  current lane contents (to read mux in0..in3)
dout  out  W  drained lane value
dout_idx  out  2  index of the lane on dout
out_valid  out  1  dout valid
busy  out  1  high while in DRAIN
drain_done  out  1  one-cycle pulse after lane 3 is accepted
wr_drop  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset (rst=1 at edge): all lanes=0, all counters=0, FSM=IDLE, every output=0. Reset overrides all other inputs, including mid-drain; the partially drained data is discarded.
- Per-lane write counter: cnt[i], $clog2(M)+1 bits.
- FSM states: IDLE, DRAIN.
- IDLE write: wr_valid=1 and cnt[sel_w_en]<M -> lane[sel_w_en] <= sum_in (overwrite; the accumulation is done in the adder) and cnt[sel_w_en]++. Visible on accN the next cycle (1-cycle latency).
- IDLE full lane: wr_valid=1 and cnt[sel_w_en]==M -> no write; wr_drop=1 next cycle.
- Width: sum_in is stored unmodified in W bits; no truncation, no sign extension.
- clear in IDLE: all lanes and counters -> 0. Same-cycle write is ignored, with no wr_drop.
- drain_start in IDLE: go to DRAIN with idx=0. A same-cycle wr_valid is still performed first, then the state changes. clear has priority over drain_start: clear is performed and the state stays IDLE.
- DRAIN outputs: out_valid=1, dout=lane[idx], dout_idx=idx, busy=1.
- DRAIN handshake: on out_valid & out_ready, idx++. dout/dout_idx are held stable while out_ready=0.
- DRAIN exit: acceptance at idx=3 clears all lanes and counters, goes to IDLE, and pulses drain_done for exactly one cycle (the first IDLE cycle). out_valid=0 in that cycle.
- In DRAIN, wr_valid -> ignored, wr_drop=1 next cycle. clear and drain_start are ignored.
- Outside DRAIN: out_valid=0, busy=0, dout=0, dout_idx=0.
- acc0..acc3 always reflect the registered lane contents, including during DRAIN.
- wr_drop and drain_done are registered single-cycle pulses. They are not sticky.

Test Plan:
- Reset then write lanes: rst 2 cycles; write 0x10->lane0, 0x2A->lane2 in consecutive cycles -> acc0=0x10 one cycle after its write, acc2=0x2A one cycle after its write; acc1=acc3=0; wr_drop never asserted.
- Lane saturation: M=16; write lane1 17 times (values 1..17) -> acc1=16 after the 16th write; the 17th write leaves acc1=16 and gives wr_drop=1 for one cycle.
- Drain with backpressure: lanes = 5,6,7,8; drain_start; out_ready toggles 0,1,0,1,1,1 -> dout sequence 5,6,7,8 with dout_idx 0..3, each value held while out_ready=0. drain_done pulses once after lane 3 is accepted; then all accN=0, busy=0.
- Priority and collisions:
  - clear + wr_valid (lane3, 0x99) in the same cycle -> acc3=0, no wr_drop.
  - clear + drain_start -> state stays IDLE, busy=0.
  - wr_valid during DRAIN -> wr_drop=1, lanes unchanged.
- Reset mid-drain: drain lanes = 1,2,3,4; assert rst after lane 1 is accepted -> next cycle out_valid=0, busy=0, all accN=0, no drain_done pulse.
- Write coincident with drain_start: wr_valid lane0 = 0x3 plus drain_start -> first drained dout=0x3 with dout_idx=0.
